// File: rtl/bra_history_tracker_if.sv
// Decode/commit/predictor-update signal bundle for the branch history tracker.
interface bra_history_tracker_if #(
  parameter int unsigned HIST_W = 2,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              dec_valid;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_prediction;
  logic [HIST_W-1:0] dec_pattern;
  logic              dec_ready;
  logic              rob_commit;
  logic              rob_taken;
  logic              rob_mispredict;
  logic              brp_update;
  logic [HIST_W-1:0] brp_pattern;
  logic [ADDR_W-1:0] brp_addr;
  logic              brp_outcome;
  logic [CNT_W-1:0]  inflight_cnt;

  // Driver side (decoder + ROB + predictor model).
  modport master (
    output dec_valid, dec_addr, dec_prediction, rob_commit, rob_taken, rob_mispredict,
    input  dec_pattern, dec_ready, brp_update, brp_pattern, brp_addr, brp_outcome,
           inflight_cnt
  );

  // Tracker side.
  modport slave (
    input  dec_valid, dec_addr, dec_prediction, rob_commit, rob_taken, rob_mispredict,
    output dec_pattern, dec_ready, brp_update, brp_pattern, brp_addr, brp_outcome,
           inflight_cnt
  );
endinterface

// File: rtl/bra_history_tracker.sv
// Global branch history tracker: speculative history for lookup, a FIFO of
// {pattern, addr} per in-flight branch, replay at commit, repair on mispredict.
module bra_history_tracker #(
  parameter int unsigned HIST_W = 2,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DEPTH  = 8
) (
  input logic                 clk,
  input logic                 rst,
  bra_history_tracker_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = HIST_W + ADDR_W;

  logic [HIST_W-1:0] spec_hist_q, spec_hist_d;
  logic [HIST_W-1:0] commit_hist_q, commit_hist_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic              brp_update_q, brp_update_d;
  logic [HIST_W-1:0] brp_pattern_q, brp_pattern_d;
  logic [ADDR_W-1:0] brp_addr_q, brp_addr_d;
  logic              brp_outcome_q, brp_outcome_d;

  logic not_full, push_ok, pop_ok, flush, push_do;

  // Shift a new outcome bit into the low end of a history register.
  function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h, input logic b);
    logic [HIST_W:0] cat;
    cat = {h, b};
    return cat[HIST_W-1:0];
  endfunction

  // Handshake qualification; a mispredict flush kills a same-cycle push.
  always_comb begin
    not_full = (cnt_q != CNT_W'(DEPTH));
    push_ok  = bus.dec_valid && not_full;
    pop_ok   = bus.rob_commit && (cnt_q != '0);
    flush    = pop_ok && bus.rob_mispredict;
    push_do  = push_ok && !flush;
  end

  // Next-state for pointers, count, histories and the predictor update register.
  always_comb begin
    commit_hist_d = pop_ok ? hist_shift(commit_hist_q, bus.rob_taken) : commit_hist_q;
    tail_d        = push_do ? tail_q + PTR_W'(1) : tail_q;
    head_d        = head_q;
    cnt_d         = cnt_q + CNT_W'(push_do) - CNT_W'(pop_ok);
    spec_hist_d   = push_do ? hist_shift(spec_hist_q, bus.dec_prediction) : spec_hist_q;
    if (pop_ok) head_d = head_q + PTR_W'(1);
    if (flush) begin
      head_d      = tail_q;
      cnt_d       = '0;
      spec_hist_d = hist_shift(commit_hist_q, bus.rob_taken);
    end
    brp_update_d  = pop_ok;
    brp_pattern_d = brp_pattern_q;
    brp_addr_d    = brp_addr_q;
    brp_outcome_d = brp_outcome_q;
    if (pop_ok) begin
      {brp_pattern_d, brp_addr_d} = mem_q[head_q];
      brp_outcome_d               = bus.rob_taken;
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_hist_q   <= '0;
      commit_hist_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      cnt_q         <= '0;
      brp_update_q  <= 1'b0;
      brp_pattern_q <= '0;
      brp_addr_q    <= '0;
      brp_outcome_q <= 1'b0;
    end else begin
      spec_hist_q   <= spec_hist_d;
      commit_hist_q <= commit_hist_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      cnt_q         <= cnt_d;
      brp_update_q  <= brp_update_d;
      brp_pattern_q <= brp_pattern_d;
      brp_addr_q    <= brp_addr_d;
      brp_outcome_q <= brp_outcome_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_do) mem_q[tail_q] <= {spec_hist_q, bus.dec_addr};
  end

  // Output drive.
  always_comb begin
    bus.dec_pattern  = spec_hist_q;
    bus.dec_ready    = not_full;
    bus.brp_update   = brp_update_q;
    bus.brp_pattern  = brp_pattern_q;
    bus.brp_addr     = brp_addr_q;
    bus.brp_outcome  = brp_outcome_q;
    bus.inflight_cnt = cnt_q;
  end
endmodule
